// File: rtl/seq_sched_pkg.sv
// Shared types and elaboration helpers for the sequence-scan scheduler.
// Holds the scheduler state enum, width derivations and the round-robin pick.
package seq_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    RESP = 2'd2
  } sched_state_t;

  // Upper bound on requesters the round-robin search can cover.
  localparam int MAX_REQ = 64;

  function automatic int calc_pat_len(input int state_bits);
    return 1 << state_bits;
  endfunction

  function automatic int calc_id_w(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

  function automatic int calc_idx_w(input int data_width);
    return $clog2(data_width);
  endfunction

  function automatic int calc_cnt_w(input int data_width);
    return $clog2(data_width + 1);
  endfunction

  // First valid requester searching upward from last_id+1; last_id if none.
  function automatic int unsigned rr_pick(input logic [MAX_REQ-1:0] valid,
                                          input int unsigned       last_id,
                                          input int unsigned       num_req);
    int unsigned pick;
    int unsigned cand;
    pick = last_id;
    // Walk offsets downward so the smallest valid offset is written last.
    for (int unsigned i = MAX_REQ; i >= 1; i--) begin
      if (i <= num_req) begin
        cand = (last_id + i) % num_req;
        if (valid[cand]) pick = cand;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/seq_match_core.sv
// Bit-serial non-overlapping pattern matcher with restart-on-mismatch.
// Pattern is loaded and the state cleared together when clear is high.
module seq_match_core
  import seq_sched_pkg::*;
#(
  parameter  int STATE_BITS = 3,
  localparam int PAT_LEN    = calc_pat_len(STATE_BITS)
) (
  input  logic                  clock0,
  input  logic                  reset,
  input  logic                  clear,
  input  logic [PAT_LEN-1:0]    pattern,
  input  logic                  bit_valid,
  input  logic                  bit_in,
  output logic                  match,
  output logic [STATE_BITS-1:0] state
);

  logic [STATE_BITS-1:0] state_q, state_d;
  logic [PAT_LEN-1:0]    pattern_q;
  logic                  hit;
  logic                  at_last;

  assign hit     = (bit_in == pattern_q[state_q]);
  assign at_last = (state_q == STATE_BITS'(PAT_LEN - 1));
  assign match   = bit_valid && hit && at_last;
  assign state   = state_q;

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = '0;
    end else if (bit_valid) begin
      if (hit) state_d = at_last ? '0 : state_q + STATE_BITS'(1);
      else     state_d = (bit_in == pattern_q[0]) ? STATE_BITS'(1) : '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clock0) begin
    if (reset) state_q <= '0;
    else       state_q <= state_d;
  end

  // NOTE: the pattern needs no reset; it is always reloaded before it is used.
  always_ff @(posedge clock0) begin
    if (clear) pattern_q <= pattern;
  end

endmodule

// File: rtl/seq_scan_scheduler.sv
// Round-robin scheduler sharing one bit-serial match core among requesters.
// IDLE arbitrates, SCAN streams the word LSB-first, RESP holds the result.
module seq_scan_scheduler
  import seq_sched_pkg::*;
#(
  parameter  int STATE_BITS = 3,
  parameter  int NUM_REQ    = 4,
  parameter  int DATA_WIDTH = 32,
  localparam int PAT_LEN    = calc_pat_len(STATE_BITS),
  localparam int ID_W       = calc_id_w(NUM_REQ),
  localparam int IDX_W      = calc_idx_w(DATA_WIDTH),
  localparam int CNT_W      = calc_cnt_w(DATA_WIDTH)
) (
  input  logic                          clock0,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*PAT_LEN-1:0]    req_pattern,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [ID_W-1:0]               rsp_id,
  output logic [CNT_W-1:0]              rsp_count,
  output logic [IDX_W-1:0]              rsp_first_idx,
  output logic                          busy,
  output logic [STATE_BITS-1:0]         match_state
);

  sched_state_t          state_q, state_d;
  logic [ID_W-1:0]       last_id_q, last_id_d, id_q, id_d, winner;
  logic [DATA_WIDTH-1:0] data_q;
  logic [IDX_W-1:0]      idx_q, idx_d, first_q, first_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  any_valid, accept, last_bit, match_pulse;

  assign any_valid = |req_valid;
  assign winner    = ID_W'(rr_pick(MAX_REQ'(req_valid), 32'(last_id_q), NUM_REQ));
  assign accept    = (state_q == IDLE) && any_valid && !reset;
  assign last_bit  = (idx_q == IDX_W'(DATA_WIDTH - 1));

  always_ff @(posedge clock0) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_valid) state_d = SCAN;
      SCAN:    if (last_bit)  state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    rsp_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      IDLE:    if (any_valid && !reset) req_ready[winner] = 1'b1;
      SCAN:    busy = 1'b1;
      RESP: begin
        busy      = 1'b1;
        rsp_valid = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    last_id_d = last_id_q;
    id_d      = id_q;
    idx_d     = idx_q;
    count_d   = count_q;
    first_d   = first_q;
    if (accept) begin
      id_d    = winner;
      idx_d   = '0;
      count_d = '0;
      first_d = '0;
    end else if (state_q == SCAN) begin
      idx_d = idx_q + IDX_W'(1);
      if (match_pulse) begin
        count_d = count_q + CNT_W'(1);
        if (count_q == '0) first_d = idx_q;
      end
    end else if (state_q == RESP && rsp_ready) begin
      last_id_d = id_q;
    end
  end

  // last_id resets to the top index so requester 0 wins the first search.
  always_ff @(posedge clock0) begin
    if (reset) begin
      last_id_q <= ID_W'(NUM_REQ - 1);
      id_q      <= '0;
      idx_q     <= '0;
      count_q   <= '0;
      first_q   <= '0;
    end else begin
      last_id_q <= last_id_d;
      id_q      <= id_d;
      idx_q     <= idx_d;
      count_q   <= count_d;
      first_q   <= first_d;
    end
  end

  always_ff @(posedge clock0) begin
    if (accept) data_q <= req_data[winner*DATA_WIDTH +: DATA_WIDTH];
  end

  assign rsp_id        = id_q;
  assign rsp_count     = count_q;
  assign rsp_first_idx = first_q;

  seq_match_core #(
    .STATE_BITS(STATE_BITS)
  ) u_core (
    .clock0   (clock0),
    .reset    (reset),
    .clear    (accept),
    .pattern  (req_pattern[winner*PAT_LEN +: PAT_LEN]),
    .bit_valid(state_q == SCAN),
    .bit_in   (data_q[idx_q]),
    .match    (match_pulse),
    .state    (match_state)
  );

endmodule

// File: tb/tb_seq_scan_scheduler.sv
// Directed bench for seq_scan_scheduler: matching, arbitration order,
// response backpressure and reset during a scan.
module tb_seq_scan_scheduler;

  logic         clock0 = 1'b0;
  logic         reset = 1'b1;
  logic [3:0]   req_valid = '0;
  logic [3:0]   req_ready;
  logic [31:0]  req_pattern = '0;
  logic [127:0] req_data = '0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic [1:0]   rsp_id;
  logic [5:0]   rsp_count;
  logic [4:0]   rsp_first_idx;
  logic         busy;
  logic [2:0]   match_state;

  int tests = 0;
  int fails = 0;
  bit mon_en = 1'b0;

  seq_scan_scheduler #(
    .STATE_BITS(3),
    .NUM_REQ   (4),
    .DATA_WIDTH(32)
  ) dut (
    .clock0       (clock0),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_pattern  (req_pattern),
    .req_data     (req_data),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_id       (rsp_id),
    .rsp_count    (rsp_count),
    .rsp_first_idx(rsp_first_idx),
    .busy         (busy),
    .match_state  (match_state)
  );

  always #5 clock0 = ~clock0;

  // Grant must be one-hot or zero, and zero whenever the scheduler is busy.
  always @(negedge clock0) begin
    if (mon_en) begin
      tests++;
      if ($countones(req_ready) > 1 || (busy && req_ready != 4'b0000)) begin
        fails++;
        $display("FAIL grant_onehot: req_ready=%b busy=%b, required one-hot/zero and zero while busy",
                 req_ready, busy);
      end
    end
  end

  task automatic tick();
    @(posedge clock0);
    #1;
  endtask

  // Drives one request and returns the observed response; ok=0 on timeout.
  task automatic do_request(input int r, input logic [7:0] pat, input logic [31:0] dat,
                            output int lat, output logic [12:0] fields, output bit ok);
    int w;
    ok = 1'b0;
    lat = 0;
    fields = '0;
    req_pattern[r*8 +: 8] = pat;
    req_data[r*32 +: 32] = dat;
    req_valid[r] = 1'b1;
    #1;
    w = 0;
    while (!req_ready[r] && w < 64) begin
      tick();
      w++;
    end
    if (!req_ready[r]) begin
      req_valid[r] = 1'b0;
      return;
    end
    tick();
    req_valid[r] = 1'b0;
    while (!rsp_valid && lat < 100) begin
      tick();
      lat++;
    end
    if (!rsp_valid) return;
    fields = {rsp_id, rsp_count, rsp_first_idx};
    ok = 1'b1;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req_valid = 4'b1111;
    repeat (3) tick();
    tests++;
    if (req_ready !== 4'b0000 || rsp_valid !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_ctrl: ready=%b rsp_valid=%b busy=%b, required 0000/0/0",
               req_ready, rsp_valid, busy);
    end
    tests++;
    if ({rsp_id, rsp_count, rsp_first_idx, match_state} !== 16'd0) begin
      fails++;
      $display("FAIL reset_fields: id=%0d cnt=%0d first=%0d ms=%0d, required all 0",
               rsp_id, rsp_count, rsp_first_idx, match_state);
    end
    req_valid = '0;
    reset = 1'b0;
    tick();
    mon_en = 1'b1;
  endtask

  task automatic test_all_ones();
    int lat;
    logic [12:0] f;
    bit ok;
    do_request(0, 8'hFF, 32'hFFFF_FFFF, lat, f, ok);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL ff_handshake: timed out waiting for grant or response");
    end
    tests++;
    if (lat != 32) begin
      fails++;
      $display("FAIL ff_latency: got %0d cycles, required 32", lat);
    end
    tests++;
    if (f !== {2'd0, 6'd4, 5'd7}) begin
      fails++;
      $display("FAIL ff_result: id/cnt/first=%0d/%0d/%0d, required 0/4/7", f[12:11], f[10:5], f[4:0]);
    end
  endtask

  task automatic test_a5();
    int lat;
    logic [12:0] f;
    bit ok;
    logic [31:0] dats [3] = '{32'h0000_00A5, 32'hA500_0000, 32'h0000_0000};
    logic [12:0] exps [3] = '{{2'd0, 6'd1, 5'd7}, {2'd0, 6'd1, 5'd31}, {2'd0, 6'd0, 5'd0}};
    for (int i = 0; i < 3; i++) begin
      do_request(0, 8'hA5, dats[i], lat, f, ok);
      tests++;
      if (!ok || f !== exps[i]) begin
        fails++;
        $display("FAIL a5_case%0d: ok=%0d id/cnt/first=%0d/%0d/%0d, required %0d/%0d/%0d", i, ok,
                 f[12:11], f[10:5], f[4:0], exps[i][12:11], exps[i][10:5], exps[i][4:0]);
      end
    end
  endtask

  task automatic test_restart();
    int lat;
    logic [12:0] f;
    bit ok;
    do_request(0, 8'h02, 32'h0000_0004, lat, f, ok);
    tests++;
    if (!ok || f !== {2'd0, 6'd1, 5'd8}) begin
      fails++;
      $display("FAIL restart: ok=%0d id/cnt/first=%0d/%0d/%0d, required 0/1/8",
               ok, f[12:11], f[10:5], f[4:0]);
    end
  endtask

  task automatic test_round_robin();
    int w;
    logic [3:0] exp_ready;
    logic [1:0] exp_id;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req_pattern = {4{8'hFF}};
    req_data = {4{32'hFFFF_FFFF}};
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    #1;
    for (int k = 0; k < 5; k++) begin
      exp_ready = 4'b0001 << (k % 4);
      exp_id = 2'(k % 4);
      w = 0;
      while (req_ready == 4'b0000 && w < 64) begin
        tick();
        w++;
      end
      tests++;
      if (req_ready !== exp_ready) begin
        fails++;
        $display("FAIL rr_grant%0d: req_ready=%b, required %b", k, req_ready, exp_ready);
      end
      tick();
      w = 0;
      while (!rsp_valid && w < 64) begin
        tick();
        w++;
      end
      tests++;
      if (!rsp_valid || rsp_id !== exp_id || rsp_count !== 6'd4) begin
        fails++;
        $display("FAIL rr_rsp%0d: valid=%0d id=%0d cnt=%0d, required 1/%0d/4",
                 k, rsp_valid, rsp_id, rsp_count, exp_id);
      end
      tick();
    end
    req_valid = '0;
    rsp_ready = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    int w;
    logic [12:0] snap;
    req_pattern[2*8 +: 8] = 8'hA5;
    req_data[2*32 +: 32] = 32'h0000_00A5;
    req_valid[2] = 1'b1;
    #1;
    w = 0;
    while (!req_ready[2] && w < 64) begin
      tick();
      w++;
    end
    tick();
    req_valid[2] = 1'b0;
    w = 0;
    while (!rsp_valid && w < 64) begin
      tick();
      w++;
    end
    snap = {rsp_id, rsp_count, rsp_first_idx};
    tests++;
    if (!rsp_valid || snap !== {2'd2, 6'd1, 5'd7}) begin
      fails++;
      $display("FAIL bp_result: valid=%0d id/cnt/first=%0d/%0d/%0d, required 1/2/1/7",
               rsp_valid, snap[12:11], snap[10:5], snap[4:0]);
    end
    req_pattern[1*8 +: 8] = 8'h0F;
    req_data[1*32 +: 32] = 32'h0000_000F;
    req_valid[1] = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      tests++;
      if (!rsp_valid || !busy || req_ready !== 4'b0000 ||
          {rsp_id, rsp_count, rsp_first_idx} !== snap) begin
        fails++;
        $display("FAIL bp_hold%0d: valid=%0d busy=%0d ready=%b fields=%h, required 1/1/0000/%h",
                 c, rsp_valid, busy, req_ready, {rsp_id, rsp_count, rsp_first_idx}, snap);
      end
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    tests++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 4'b0010) begin
      fails++;
      $display("FAIL bp_release: valid=%0d busy=%0d ready=%b, required 0/0/0010",
               rsp_valid, busy, req_ready);
    end
    req_valid[1] = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_scan();
    int w;
    int lat;
    bit stale;
    req_pattern[1*8 +: 8] = 8'hFF;
    req_data[1*32 +: 32] = 32'hFFFF_FFFF;
    req_valid[1] = 1'b1;
    #1;
    w = 0;
    while (!req_ready[1] && w < 64) begin
      tick();
      w++;
    end
    tick();
    req_valid[1] = 1'b0;
    repeat (10) tick();
    reset = 1'b1;
    req_pattern[0*8 +: 8] = 8'hA5;
    req_data[0*32 +: 32] = 32'h0000_00A5;
    req_pattern[3*8 +: 8] = 8'hFF;
    req_data[3*32 +: 32] = 32'hFFFF_FFFF;
    req_valid = 4'b1001;
    tick();
    tests++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 4'b0000 ||
        {rsp_id, rsp_count, rsp_first_idx, match_state} !== 16'd0) begin
      fails++;
      $display("FAIL rst_scan_state: busy=%0d valid=%0d ready=%b cnt=%0d ms=%0d, required 0/0/0000/0/0",
               busy, rsp_valid, req_ready, rsp_count, match_state);
    end
    reset = 1'b0;
    #1;
    tests++;
    if (req_ready !== 4'b0001) begin
      fails++;
      $display("FAIL rst_scan_priority: req_ready=%b, required 0001", req_ready);
    end
    tick();
    req_valid = '0;
    lat = 0;
    while (!rsp_valid && lat < 100) begin
      tick();
      lat++;
    end
    tests++;
    if (lat != 32 || {rsp_id, rsp_count, rsp_first_idx} !== {2'd0, 6'd1, 5'd7}) begin
      fails++;
      $display("FAIL rst_scan_next: lat=%0d id/cnt/first=%0d/%0d/%0d, required 32/0/1/7",
               lat, rsp_id, rsp_count, rsp_first_idx);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    stale = 1'b0;
    repeat (40) begin
      tick();
      if (rsp_valid) stale = 1'b1;
    end
    tests++;
    if (stale) begin
      fails++;
      $display("FAIL rst_scan_drop: unexpected response after dropped request, required none");
    end
  endtask

  initial begin
    test_reset();
    test_all_ones();
    test_a5();
    test_restart();
    test_round_robin();
    test_backpressure();
    test_reset_mid_scan();
    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
